// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle processor datapath: sequences the PC/IR/regfile/memory
// enables and datapath muxes per instruction class, and decodes the ALU control code.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    state_e     w_state_out;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch: w_state_next = StDecode;
            StDecode: begin
                if (op == OP_LW || op == OP_SW) w_state_next = StMemAdr;
                else if (op == OP_RTYPE)        w_state_next = StRtypeEx;
                else if (op == OP_BEQ)          w_state_next = StBeqEx;
                else if (op == OP_ADDI)         w_state_next = StAddiEx;
                else if (op == OP_J)            w_state_next = StJEx;
                else                            w_state_next = StFetch;
            end
            StMemAdr:  w_state_next = (op == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   w_state_next = StMemWb;
            StRtypeEx: w_state_next = StRtypeWb;
            StAddiEx:  w_state_next = StAddiWb;
            default:   w_state_next = StFetch;
        endcase
    end

    // During reset the decode shows FETCH values; the enables are masked below.
    assign w_state_out = reset ? StFetch : r_state;

    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        w_aluop    = 2'b00;
        case (w_state_out)
            StFetch: begin
                alusrcb   = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            StDecode:  alusrcb = 2'b11;
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd:   iord = 1'b1;
            StMemWb: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            StRtypeWb: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StAddiWb:  w_regwrite = 1'b1;
            StJEx: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
    assign irwrite  = ~reset & w_irwrite;
    assign memwrite = ~reset & w_memwrite;
    assign regwrite = ~reset & w_regwrite;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table over every instruction class and reset,
// then cycles-per-instruction and R-type funct decode sequences.
module tb_multicycle_ctrl;

    localparam logic [5:0] L_RT  = 6'b000000;
    localparam logic [5:0] L_LW  = 6'b100011;
    localparam logic [5:0] L_SW  = 6'b101011;
    localparam logic [5:0] L_BEQ = 6'b000100;
    localparam logic [5:0] L_ADI = 6'b001000;
    localparam logic [5:0] L_J   = 6'b000010;
    localparam logic [5:0] L_BAD = 6'b111111;

    // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
    localparam logic [14:0] E_RST  = 15'b0_0_0_0_0_0_0_0_01_00_010;
    localparam logic [14:0] E_F    = 15'b1_1_0_0_0_0_0_0_01_00_010;
    localparam logic [14:0] E_D    = 15'b0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [14:0] E_MADR = 15'b0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [14:0] E_MRD  = 15'b0_0_0_0_1_0_0_0_00_00_010;
    localparam logic [14:0] E_MWB  = 15'b0_0_0_1_0_1_0_0_00_00_010;
    localparam logic [14:0] E_MWR  = 15'b0_0_1_0_1_0_0_0_00_00_010;
    localparam logic [14:0] E_RSUB = 15'b0_0_0_0_0_0_0_1_00_00_110;
    localparam logic [14:0] E_RSLT = 15'b0_0_0_0_0_0_0_1_00_00_111;
    localparam logic [14:0] E_RWB  = 15'b0_0_0_1_0_0_1_0_00_00_010;
    localparam logic [14:0] E_BEQ1 = 15'b1_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] E_BEQ0 = 15'b0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] E_AWB  = 15'b0_0_0_1_0_0_0_0_00_00_010;
    localparam logic [14:0] E_J    = 15'b1_0_0_0_0_0_0_0_00_10_010;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [14:0] exp;
    } vec_t;

    localparam int NVEC = 40;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [14:0] w_act;

    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    assign w_act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                    alusrcb, pcsrc, alucontrol};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic [14:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        return v;
    endfunction

    // Starting in FETCH, count cycles until irwrite reasserts.
    task automatic run_cpi(input logic [5:0] o, input int exp_n, input string name);
        int  n;
        bit  done;
        n = 1;
        done = 0;
        op = o;
        repeat (10) begin
            if (!done) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (irwrite) done = 1;
                else n++;
            end
        end
        checks++;
        if (!done || n != exp_n) begin
            failures++;
            $display("FAIL cpi_%s: got %0d cycles (done=%0d), expected %0d", name, n, done, exp_n);
        end
    endtask

    task automatic run_rtype_alu(input logic [5:0] f, input logic [2:0] exp_alu);
        op = L_RT;
        funct = f;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (alucontrol !== exp_alu || regwrite !== 1'b0) begin
            failures++;
            $display("FAIL rtype_funct_%b: alucontrol=%b regwrite=%b, expected alucontrol=%b regwrite=0",
                     f, alucontrol, regwrite, exp_alu);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs[0]  = mk(1'b1, L_RT,  6'd0,      1'b0, E_RST);
        vecs[1]  = mk(1'b1, L_RT,  6'd0,      1'b0, E_RST);
        vecs[2]  = mk(1'b0, L_LW,  6'd0,      1'b0, E_F);
        vecs[3]  = mk(1'b0, L_LW,  6'd0,      1'b0, E_D);
        vecs[4]  = mk(1'b0, L_LW,  6'd0,      1'b0, E_MADR);
        vecs[5]  = mk(1'b0, L_LW,  6'd0,      1'b0, E_MRD);
        vecs[6]  = mk(1'b0, L_LW,  6'd0,      1'b0, E_MWB);
        vecs[7]  = mk(1'b0, L_SW,  6'd0,      1'b0, E_F);
        vecs[8]  = mk(1'b0, L_SW,  6'd0,      1'b0, E_D);
        vecs[9]  = mk(1'b0, L_SW,  6'd0,      1'b0, E_MADR);
        vecs[10] = mk(1'b0, L_SW,  6'd0,      1'b0, E_MWR);
        vecs[11] = mk(1'b0, L_RT,  6'b100010, 1'b0, E_F);
        vecs[12] = mk(1'b0, L_RT,  6'b100010, 1'b0, E_D);
        vecs[13] = mk(1'b0, L_RT,  6'b100010, 1'b0, E_RSUB);
        vecs[14] = mk(1'b0, L_RT,  6'b100010, 1'b0, E_RWB);
        vecs[15] = mk(1'b0, L_RT,  6'b101010, 1'b0, E_F);
        vecs[16] = mk(1'b0, L_RT,  6'b101010, 1'b0, E_D);
        vecs[17] = mk(1'b0, L_RT,  6'b101010, 1'b0, E_RSLT);
        vecs[18] = mk(1'b0, L_RT,  6'b101010, 1'b0, E_RWB);
        vecs[19] = mk(1'b0, L_BEQ, 6'd0,      1'b1, E_F);
        vecs[20] = mk(1'b0, L_BEQ, 6'd0,      1'b1, E_D);
        vecs[21] = mk(1'b0, L_BEQ, 6'd0,      1'b1, E_BEQ1);
        vecs[22] = mk(1'b0, L_BEQ, 6'd0,      1'b0, E_F);
        vecs[23] = mk(1'b0, L_BEQ, 6'd0,      1'b0, E_D);
        vecs[24] = mk(1'b0, L_BEQ, 6'd0,      1'b0, E_BEQ0);
        vecs[25] = mk(1'b0, L_BAD, 6'd0,      1'b1, E_F);
        vecs[26] = mk(1'b0, L_BAD, 6'd0,      1'b1, E_D);
        vecs[27] = mk(1'b0, L_J,   6'd0,      1'b1, E_F);
        vecs[28] = mk(1'b0, L_J,   6'd0,      1'b0, E_D);
        vecs[29] = mk(1'b0, L_J,   6'd0,      1'b0, E_J);
        vecs[30] = mk(1'b0, L_ADI, 6'd0,      1'b0, E_F);
        vecs[31] = mk(1'b0, L_ADI, 6'd0,      1'b0, E_D);
        vecs[32] = mk(1'b0, L_ADI, 6'd0,      1'b1, E_MADR);
        vecs[33] = mk(1'b0, L_ADI, 6'd0,      1'b0, E_AWB);
        vecs[34] = mk(1'b0, L_LW,  6'd0,      1'b0, E_F);
        vecs[35] = mk(1'b0, L_LW,  6'd0,      1'b0, E_D);
        vecs[36] = mk(1'b1, L_LW,  6'd0,      1'b0, E_RST);
        vecs[37] = mk(1'b1, L_LW,  6'd0,      1'b0, E_RST);
        vecs[38] = mk(1'b0, L_LW,  6'd0,      1'b0, E_F);
        vecs[39] = mk(1'b0, L_LW,  6'd0,      1'b0, E_D);

        for (int i = 0; i < NVEC; i++) begin
            reset = vecs[i].rst;
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            @(negedge clk);
            checks++;
            if (w_act !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d: outputs=%b expected=%b", i, w_act, vecs[i].exp);
            end
            @(posedge clk); #1;
        end

        // Back to FETCH from MEMADR via a one-cycle reset.
        reset = 1'b1;
        zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        run_cpi(L_LW,  5, "lw");
        run_cpi(L_SW,  4, "sw");
        run_cpi(L_RT,  4, "rtype");
        run_cpi(L_ADI, 4, "addi");
        run_cpi(L_BEQ, 3, "beq");
        run_cpi(L_J,   3, "j");
        run_cpi(L_BAD, 2, "illegal");

        // run_cpi leaves us at the negedge of a FETCH cycle.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_rtype_alu(6'b100000, 3'b010);
        run_rtype_alu(6'b100100, 3'b000);
        run_rtype_alu(6'b100101, 3'b001);
        run_rtype_alu(6'b110011, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
